// File: rtl/mem_access_unit.sv
// Memory-access stage: passes ALU results through or performs byte/half/word
// loads and stores over a req/ack port, producing one registered write-back record per accept.
module mem_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_size,
    input  logic            ex_unsigned,
    input  logic            ex_reg_write,
    input  logic [4:0]      ex_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_fault
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_fault_q, wb_fault_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;

    logic            accept;
    logic            mem_op;
    logic            fault_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] load_c;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign mem_op   = ex_mem_read | ex_mem_write;

    // Conflicting direction, illegal size, or natural misalignment.
    assign fault_c = (ex_mem_read & ex_mem_write)
                   | (mem_op & ((ex_size == 2'b11)
                              | ((ex_size == 2'b01) & ex_alu_result[0])
                              | ((ex_size == 2'b10) & (ex_alu_result[1:0] != 2'b00))));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = ex_store_data;
        case (ex_size)
            2'b00: begin
                be_c    = 4'b0001 << ex_alu_result[1:0];
                wdata_c = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                be_c    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Align the addressed lane to bit 0, then extend to full width.
    assign lane_data = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_c = lane_data;
        case (size_q)
            2'b00: load_c = unsigned_q ? {{(XLEN-8){1'b0}}, lane_data[7:0]}
                                       : {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
            2'b01: load_c = unsigned_q ? {{(XLEN-16){1'b0}}, lane_data[15:0]}
                                       : {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_fault_d     = wb_fault_q;
        lane_d         = lane_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fault_c) begin
                        wb_valid_d     = 1'b1;
                        wb_fault_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                        wb_data_d      = '0;
                        wb_rd_d        = ex_rd;
                    end else if (!mem_op) begin
                        wb_valid_d     = 1'b1;
                        wb_fault_d     = 1'b0;
                        wb_reg_write_d = ex_reg_write;
                        wb_data_d      = ex_alu_result;
                        wb_rd_d        = ex_rd;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ex_mem_write;
                        mem_addr_d  = {ex_alu_result[XLEN-1:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                        lane_d      = ex_alu_result[1:0];
                        size_d      = ex_size;
                        unsigned_d  = ex_unsigned;
                        rd_d        = ex_rd;
                        reg_write_d = ex_reg_write;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_fault_d     = 1'b0;
                    wb_rd_d        = rd_q;
                    wb_data_d      = mem_we_q ? '0 : load_c;
                    wb_reg_write_d = mem_we_q ? 1'b0 : reg_write_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_fault_q     <= 1'b0;
            lane_q         <= '0;
            size_q         <= '0;
            unsigned_q     <= 1'b0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_fault_q     <= wb_fault_d;
            lane_q         <= lane_d;
            size_q         <= size_d;
            unsigned_q     <= unsigned_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_fault     = wb_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: lane-level reference model checked every cycle,
// a responding memory with programmable latency, and literal spot checks.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [1:0]  ex_size = '0;
    logic        ex_unsigned = 1'b0;
    logic        ex_reg_write = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_reg_write, wb_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rules expressed over byte lanes and access sizes.
    function automatic bit is_fault(bit rd, bit wr, logic [1:0] size, logic [31:0] addr);
        if (rd && wr) return 1'b1;
        if (!(rd || wr)) return 1'b0;
        if (size == 2'b11) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [3:0] lanes_of(logic [31:0] addr, int n);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= int'(addr[1:0])) && (i < int'(addr[1:0]) + n);
        return be;
    endfunction

    function automatic logic [31:0] wdata_of(logic [31:0] d, int n);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_of(logic [31:0] rdw, logic [1:0] off, int n, bit uns);
        logic [31:0] v = '0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = rdw[8*(int'(off) + j) +: 8];
        if (!uns && v[8*n-1])
            for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    typedef struct {
        int          due;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fault;
    } wb_t;

    wb_t         exp_q[$];
    bit          busy = 0;
    int          age = 0;
    int          lat = 1;
    logic [31:0] rword = '0;
    bit          stray_ack = 0;
    logic        r_we, r_uns, r_rw;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    int          r_n;

    // Model, memory responder and per-cycle compare, all at the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy = 0;
            exp_q.delete();
            mem_ack = 1'b0;
            chk("rst ex_ready", 32'(ex_ready), 32'd1);
            chk("rst mem_req", 32'(mem_req), 32'd0);
            chk("rst mem_we", 32'(mem_we), 32'd0);
            chk("rst mem_addr", mem_addr, 32'd0);
            chk("rst mem_be", 32'(mem_be), 32'd0);
            chk("rst mem_wdata", mem_wdata, 32'd0);
            chk("rst wb_valid", 32'(wb_valid), 32'd0);
            chk("rst wb_reg_write", 32'(wb_reg_write), 32'd0);
            chk("rst wb_rd", 32'(wb_rd), 32'd0);
            chk("rst wb_data", wb_data, 32'd0);
            chk("rst wb_fault", 32'(wb_fault), 32'd0);
        end else begin
            bit was_busy;
            bit exp_wb;
            was_busy = busy;
            chk("ex_ready", 32'(ex_ready), 32'(!busy));
            chk("mem_req", 32'(mem_req), 32'(busy));
            if (busy) begin
                chk("mem_we", 32'(mem_we), 32'(r_we));
                chk("mem_addr", mem_addr, r_addr);
                chk("mem_be", 32'(mem_be), 32'(r_be));
                chk("mem_wdata", mem_wdata, r_wdata);
            end
            exp_wb = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
            if (exp_wb) begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("wb_fault", 32'(wb_fault), 32'(e.fault));
            end
            mem_ack = 1'b0;
            if (busy) begin
                age++;
                if (age == lat) begin
                    wb_t e;
                    mem_ack = 1'b1;
                    mem_rdata = rword;
                    e.due = cyc + 1;
                    e.rd = r_rd;
                    e.fault = 1'b0;
                    e.rw = r_we ? 1'b0 : r_rw;
                    e.data = r_we ? 32'd0 : load_of(rword, r_off, r_n, r_uns);
                    exp_q.push_back(e);
                    busy = 0;
                end
            end else begin
                mem_ack = stray_ack;
            end
            if (!was_busy && ex_valid) begin
                wb_t e;
                e.due = cyc + 1;
                e.rd = ex_rd;
                if (is_fault(ex_mem_read, ex_mem_write, ex_size, ex_alu_result)) begin
                    e.rw = 1'b0; e.data = 32'd0; e.fault = 1'b1;
                    exp_q.push_back(e);
                end else if (!(ex_mem_read || ex_mem_write)) begin
                    e.rw = ex_reg_write; e.data = ex_alu_result; e.fault = 1'b0;
                    exp_q.push_back(e);
                end else begin
                    busy = 1; age = 0;
                    r_n = 1 << ex_size;
                    r_we = ex_mem_write;
                    r_addr = ex_alu_result & ~32'd3;
                    r_be = lanes_of(ex_alu_result, r_n);
                    r_wdata = wdata_of(ex_store_data, r_n);
                    r_off = ex_alu_result[1:0];
                    r_uns = ex_unsigned;
                    r_rw = ex_reg_write;
                    r_rd = ex_rd;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a record and hold it until the unit accepts it.
    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input bit rd,
                         input bit wr, input logic [1:0] size, input bit uns,
                         input bit rw, input logic [4:0] dst);
        bit r;
        bit done = 0;
        ex_alu_result = alu; ex_store_data = sd; ex_mem_read = rd; ex_mem_write = wr;
        ex_size = size; ex_unsigned = uns; ex_reg_write = rw; ex_rd = dst;
        ex_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = ex_ready;
            @(posedge clk);
            done = r;
        end
        #1;
        if (!done) chk("accept timeout ex_ready", 32'(ex_ready), 32'd1);
        ex_valid = 1'b0;
    endtask

    task automatic wait_wb(input string name, input logic [31:0] d, input bit rw, input bit f);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                seen = 1;
                chk({name, " data"}, wb_data, d);
                chk({name, " reg_write"}, 32'(wb_reg_write), 32'(rw));
                chk({name, " fault"}, 32'(wb_fault), 32'(f));
            end
        end
        if (!seen) chk({name, " wb_valid timeout"}, 32'(wb_valid), 32'd1);
        step();
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;
        step();

        issue(32'hDEADBEEF, 0, 0, 0, 2'b10, 0, 1, 5'd7);
        @(negedge clk);
        chk("pass wb_valid cycle1", 32'(wb_valid), 32'd1);
        chk("pass wb_data", wb_data, 32'hDEADBEEF);
        chk("pass wb_rd", 32'(wb_rd), 32'd7);
        step();

        lat = 3; rword = 32'h80FF_0000;
        issue(32'h1003, 0, 1, 0, 2'b00, 0, 1, 5'd3);
        @(negedge clk);
        chk("lb mem_addr", mem_addr, 32'h1000);
        chk("lb mem_be", 32'(mem_be), 32'h8);
        wait_wb("lb signed", 32'hFFFFFF80, 1, 0);
        issue(32'h1003, 0, 1, 0, 2'b00, 1, 1, 5'd4);
        wait_wb("lbu", 32'h00000080, 1, 0);

        lat = 2;
        issue(32'h2002, 32'h1234ABCD, 0, 1, 2'b01, 0, 1, 5'd5);
        @(negedge clk);
        chk("sh mem_we", 32'(mem_we), 32'd1);
        chk("sh mem_be", 32'(mem_be), 32'hC);
        chk("sh mem_wdata", mem_wdata, 32'hABCDABCD);
        wait_wb("sh", 32'd0, 0, 0);

        issue(32'h3001, 0, 1, 0, 2'b10, 0, 1, 5'd8);
        wait_wb("lw misaligned", 32'd0, 0, 1);
        issue(32'h3001, 0, 1, 0, 2'b01, 0, 1, 5'd9);
        wait_wb("lh misaligned", 32'd0, 0, 1);
        issue(32'h3000, 0, 1, 0, 2'b11, 0, 1, 5'd10);
        wait_wb("size11", 32'd0, 0, 1);
        issue(32'h3000, 0, 1, 1, 2'b10, 0, 1, 5'd11);
        wait_wb("rd and wr", 32'd0, 0, 1);

        lat = 1; rword = 32'hCAFE_8001;
        issue(32'h4002, 0, 1, 0, 2'b01, 0, 1, 5'd12);
        wait_wb("lh zero-wait", 32'hFFFFCAFE, 1, 0);
        issue(32'h4000, 32'h5566_7788, 0, 1, 2'b00, 0, 0, 5'd13);
        wait_wb("sb zero-wait", 32'd0, 0, 0);

        lat = 2; rword = 32'h0102_0304;
        issue(32'h5000, 0, 1, 0, 2'b10, 0, 1, 5'd14);
        issue(32'h0000_0042, 0, 0, 0, 2'b00, 0, 1, 5'd15);
        wait_wb("pass after load", 32'h42, 1, 0);

        lat = 1000;
        issue(32'h100, 0, 1, 0, 2'b10, 0, 1, 5'd16);
        step();
        rst = 1'b1;
        #1;
        chk("async rst mem_req", 32'(mem_req), 32'd0);
        chk("async rst mem_addr", mem_addr, 32'd0);
        step();
        rst = 1'b0;
        lat = 1;
        stray_ack = 1;
        repeat (3) step();
        stray_ack = 0;
        repeat (3) step();
        chk("queue drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
